adder_share_arbiter: RTL and testbench

- Shares one 32-bit carry-lookahead adder core between NREQ requesters, each with a valid/ready handshake.
- Round-robin arbitration, registered operands, one registered result slot with id tag, stalled by downstream back-pressure.
- Supports add and subtract per request. Sits between ALU-side clients and the single shared adder instance.

---
 rtl/adder_share_arbiter_pkg.sv | 25 ++
 rtl/adder_share_arbiter_cla.sv | 53 +++++
 rtl/adder_share_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder_share_arbiter slice.
//   W           : operand width of the shared adder core (fixed at 32)
//   id_width()  : requester-index width for 2..8 requesters
//   slot_state_e: occupancy of the registered result slot
package adder_share_arbiter_pkg;

  localparam int W = 32;

  // Index width for the supported requester counts (2..8).
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else if (n <= 4) begin
      return 2;
    end else begin
      return 3;
    end
  endfunction

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/adder_share_arbiter_cla.sv
// 32-bit carry-lookahead adder core, purely combinational.
//   a, b  : operands
//   cin   : carry-in
//   s     : sum
//   cout  : carry out of the MSB
//   ovf   : signed overflow (carry into MSB differs from carry out of MSB)
// Carries are resolved with full lookahead inside each 4-bit group; group
// carries then chain from group to group.
module adder_share_arbiter_cla
  import adder_share_arbiter_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W:0]   c_s;

  // Generate/propagate terms and per-group lookahead carries.
  always_comb begin
    logic cg;
    int   base;
    g_s = a & b;
    p_s = a ^ b;
    c_s = '0;
    cg  = cin;
    for (int grp = 0; grp < W / 4; grp++) begin
      base         = grp * 4;
      c_s[base]    = cg;
      c_s[base+1]  = g_s[base] | (p_s[base] & cg);
      c_s[base+2]  = g_s[base+1] | (p_s[base+1] & g_s[base])
                   | (p_s[base+1] & p_s[base] & cg);
      c_s[base+3]  = g_s[base+2] | (p_s[base+2] & g_s[base+1])
                   | (p_s[base+2] & p_s[base+1] & g_s[base])
                   | (p_s[base+2] & p_s[base+1] & p_s[base] & cg);
      cg           = g_s[base+3] | (p_s[base+3] & g_s[base+2])
                   | (p_s[base+3] & p_s[base+2] & g_s[base+1])
                   | (p_s[base+3] & p_s[base+2] & p_s[base+1] & g_s[base])
                   | (p_s[base+3] & p_s[base+2] & p_s[base+1] & p_s[base] & cg);
    end
    c_s[W] = cg;
  end

  assign s    = p_s ^ c_s[W-1:0];
  assign cout = c_s[W];
  assign ovf  = c_s[W] ^ c_s[W-1];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin front end sharing one 32-bit adder core among NREQ requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b       : packed operands, requester i at [i*W +: W]
//   req_sub/req_cin   : per-requester subtract select and add carry-in
//   rsp_valid/ready   : result slot handshake
//   rsp_id/sum/cout/ovf : registered result tagged with the owner's index
// Pipeline: accept -> operand register (stage 1) -> core -> result slot.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ-1:0]     req_sub,
  input  logic [NREQ-1:0]     req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_ovf
);

  logic            op_valid_q, op_valid_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            op_cin_q, op_cin_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  slot_state_e     slot_q, slot_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_ovf_q, rsp_ovf_d;

  logic [IDW-1:0]  grant_s;
  logic            found_s;
  logic            slot_load_s;
  logic            op_load_s;
  logic            accept_s;
  logic [W-1:0]    core_sum_s;
  logic            core_cout_s;
  logic            core_ovf_s;

  adder_share_arbiter_cla u_core (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .s    (core_sum_s),
    .cout (core_cout_s),
    .ovf  (core_ovf_s)
  );

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = IDW'(idx);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pipeline advance conditions and the one-hot accept.
  always_comb begin
    slot_load_s = op_valid_q && ((slot_q == SLOT_EMPTY) || rsp_ready);
    op_load_s   = !op_valid_q || slot_load_s;
    accept_s    = op_load_s && found_s;
    req_ready   = '0;
    if (accept_s && rst_n) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Stage-1 operand register and round-robin pointer next state.
  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    op_id_d    = op_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (op_load_s) begin
      op_valid_d = accept_s;
    end else begin
      op_valid_d = op_valid_q;
    end
    if (accept_s) begin
      // Subtract is A + ~B + 1; the requester's carry-in is ignored then.
      op_a_d   = req_a[int'(grant_s)*W +: W];
      op_b_d   = req_sub[grant_s] ? ~req_b[int'(grant_s)*W +: W]
                                  :  req_b[int'(grant_s)*W +: W];
      op_cin_d = req_sub[grant_s] ? 1'b1 : req_cin[grant_s];
      op_id_d  = grant_s;
      rr_ptr_d = (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + IDW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Result slot state machine; contents hold while stalled.
  always_comb begin
    slot_d     = slot_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    case (slot_q)
      SLOT_EMPTY: begin
        if (slot_load_s) begin
          slot_d = SLOT_FULL;
        end else begin
          slot_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (slot_load_s) begin
          slot_d = SLOT_FULL;
        end else if (rsp_ready) begin
          slot_d = SLOT_EMPTY;
        end else begin
          slot_d = SLOT_FULL;
        end
      end
      default: begin
        slot_d = SLOT_EMPTY;
      end
    endcase
    if (slot_load_s) begin
      rsp_id_d   = op_id_q;
      rsp_sum_d  = core_sum_s;
      rsp_cout_d = core_cout_s;
      rsp_ovf_d  = core_ovf_s;
    end else begin
      rsp_id_d   = rsp_id_q;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      op_id_q    <= '0;
      rr_ptr_q   <= '0;
      slot_q     <= SLOT_EMPTY;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      op_id_q    <= op_id_d;
      rr_ptr_q   <= rr_ptr_d;
      slot_q     <= slot_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid = (slot_q == SLOT_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          age;
  } exp_t;

  exp_t mq[$];
  int   mptr  = 0;
  int   nresp = 0;

  // Result from plain integer arithmetic on the requested operation.
  function automatic exp_t model_op(input logic [1:0] id, input logic [31:0] a,
                                    input logic [31:0] b, input logic sub, input logic cin);
    exp_t e;
    longint sa, sb, sr, ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      sr     = sa - sb;
      ur     = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      sr     = sa + sb + longint'(cin);
      ur     = ua + ub + longint'(cin);
      e.cout = (ur > 64'sh0000_0000_FFFF_FFFF);
    end
    e.id  = id;
    e.sum = ur[31:0];
    e.ovf = (sr > SMAX) || (sr < SMIN);
    e.age = 0;
    return e;
  endfunction

  bit         vis, drain, room, found;
  int         g, idx;
  logic [3:0] exp_rdy;

  // Capacity-two in-order queue: an entry becomes visible one edge after
  // acceptance; new work fits when fewer than two remain after draining.
  always @(negedge clk) begin : model
    if (!rst_n) begin
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_id",    64'(rsp_id),    64'd0);
      check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
      check("rst_rsp_cout",  64'(rsp_cout),  64'd0);
      check("rst_rsp_ovf",   64'(rsp_ovf),   64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      mq.delete();
      mptr = 0;
    end else begin
      vis = (mq.size() > 0) && (mq[0].age > 0);
      check("rsp_valid", 64'(rsp_valid), 64'(vis));
      if (vis) begin
        check("rsp_id",   64'(rsp_id),   64'(mq[0].id));
        check("rsp_sum",  64'(rsp_sum),  64'(mq[0].sum));
        check("rsp_cout", 64'(rsp_cout), 64'(mq[0].cout));
        check("rsp_ovf",  64'(rsp_ovf),  64'(mq[0].ovf));
      end
      drain = vis && rsp_ready;
      room  = (mq.size() - (drain ? 1 : 0)) < 2;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      exp_rdy = (room && found) ? 4'(1 << g) : 4'd0;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (drain) begin
        void'(mq.pop_front());
        nresp++;
      end
      foreach (mq[k]) mq[k].age = 1;
      if (room && found) begin
        mq.push_back(model_op(2'(g), req_a[g*W +: W], req_b[g*W +: W], req_sub[g], req_cin[g]));
        mptr = (g + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int sent[NREQ];
  int quota[NREQ];
  int rec[8];
  int rec_n  = 0;
  bit rec_on = 1'b0;

  task automatic load_op(input int i, input int j);
    req_a[i*W +: W] = 32'(32'h0100_0000 * i + 32'h11 * j + 32'h5);
    req_b[i*W +: W] = 32'(3 * j + i + 1);
    req_sub[i]      = j[0];
    req_cin[i]      = i[0];
  endtask

  // One clock: note accepts before the edge, then advance each requester.
  task automatic step();
    logic [NREQ-1:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i]) begin
        if (rec_on && rec_n < 8) begin
          rec[rec_n] = i;
          rec_n++;
        end
        sent[i]++;
        if (sent[i] < quota[i]) load_op(i, sent[i]);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic start_stream(input int q);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      quota[i]     = q;
      sent[i]      = 0;
      load_op(i, 0);
      req_valid[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((req_valid != '0 || mq.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check({name, "_idle"}, 64'(req_valid == '0 && mq.size() == 0), 64'd1);
  endtask

  task automatic do_one(input string name, input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [31:0] esum,
                        input logic ecout, input logic eovf);
    int   n;
    logic got;
    @(posedge clk);
    #1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = sub;
    req_cin[i]      = cin;
    req_valid[i]    = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = req_ready[i];
      n++;
    end
    check({name, "_accept"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check({name, "_lat_early"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(rsp_valid), 64'd1);
    check({name, "_id"},    64'(rsp_id),    64'(i));
    check({name, "_sum"},   64'(rsp_sum),   64'(esum));
    check({name, "_cout"},  64'(rsp_cout),  64'(ecout));
    check({name, "_ovf"},   64'(rsp_ovf),   64'(eovf));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int n0;
    logic [NREQ-1:0] f;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_cin   = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // Single operations with hand-computed results.
    do_one("add",    0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    do_one("sub",    2, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_one("ovf",    1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_one("subcin", 1, 32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0);
    do_one("carry",  3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_one("cin",    3, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0031, 1'b0, 1'b0);

    // Round-robin with everyone valid; pointer sits at 0 here.
    rec_on = 1'b1;
    start_stream(3);
    wait_idle("rr");
    rec_on = 1'b0;
    for (int k = 0; k < 8; k++) check("rr_order", 64'(rec[k]), 64'(k % 4));

    // Back-pressure with two results in flight.
    @(posedge clk);
    #1;
    rsp_ready      = 1'b0;
    req_a[1*W +: W] = 32'd100;
    req_b[1*W +: W] = 32'd1;
    req_sub[1]     = 1'b0;
    req_cin[1]     = 1'b0;
    req_a[3*W +: W] = 32'h50;
    req_b[3*W +: W] = 32'h20;
    req_sub[3]     = 1'b1;
    req_valid[1]   = 1'b1;
    req_valid[3]   = 1'b1;
    n = 0;
    while ((req_valid[1] || req_valid[3]) && n < 10) begin
      @(negedge clk);
      f = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (f[1]) req_valid[1] = 1'b0;
      if (f[3]) req_valid[3] = 1'b0;
      n++;
    end
    check("bp_both_accepted", 64'(req_valid), 64'd0);
    req_a[0 +: W] = 32'd1;
    req_b[0 +: W] = 32'd1;
    req_sub[0]    = 1'b0;
    req_cin[0]    = 1'b0;
    req_valid[0]  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_zero", 64'(req_ready), 64'd0);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_id",    64'(rsp_id),    64'd1);
      check("bp_hold_sum",   64'(rsp_sum),   64'd101);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    n0 = nresp;
    @(negedge clk);
    check("bp_first_id",  64'(rsp_id),    64'd1);
    check("bp_refill",    64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_second_id",   64'(rsp_id),   64'd3);
    check("bp_second_sum",  64'(rsp_sum),  64'h30);
    check("bp_second_cout", 64'(rsp_cout), 64'd1);
    wait_idle("bp");
    check("bp_count", 64'(nresp - n0), 64'd3);

    // Reset in the middle of busy traffic.
    start_stream(50);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_sum",   64'(rsp_sum),   64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < NREQ; i++) begin
      sent[i]  = 0;
      quota[i] = 4;
      load_op(i, 0);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    check("post_rst_valid", 64'(rsp_valid), 64'd1);
    check("post_rst_id",    64'(rsp_id),    64'd0);
    check("post_rst_sum",   64'(rsp_sum),   64'd6);
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
